sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Parametrised asynchronous-SRAM controller; the successor to the fixed 16-bit/20-bit SRAM hookup used by the SLC-3 top level.
- Sits between the CPU memory-access logic and the physical SRAM pins (CE/UB/LB/OE/WE/ADDR/Data) or test_memory in simulation.
- Converts a single-cycle request handshake into a timed SRAM read or write with programmable wait states and per-byte enables.
- Inserts bus-turnaround cycles between a read and a following write.

Parameters:
- DATA_W, 16: data width in bits; must be a multiple of 8.
- ADDR_W, 20: address width in bits.
- RD_WAIT, 1: extra cycles OE is held low beyond the first (read strobe length = RD_WAIT+1 cycles).
- WR_WAIT, 1: extra cycles WE is held low beyond the first (write pulse length = WR_WAIT+1 cycles).
- TURN_CYC, 1: idle cycles inserted before a write that directly follows a read; 0 disables turnaround.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; latched with req.
- addr  in  ADDR_W  word address; latched with req.
- wdata  in  DATA_W  write data; latched with req.
- be  in  DATA_W/8  byte enables, active-high; latched with req.
- busy  out  1  high whenever state is not IDLE.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while ack is high and held until the next read completes.
- CE  out  1  chip enable, active-low.
- OE  out  1  output enable, active-low.
- WE  out  1  write enable, active-low.
- BE_N  out  DATA_W/8  per-byte lane enables, active-low (lane 0 = LB, lane 1 = UB when DATA_W=16).
- ADDR  out  ADDR_W  SRAM address.
- Data  inout  DATA_W  SRAM data bus; high-Z unless this block is writing.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - CE, OE, WE = 1; BE_N = all 1s.
  - ADDR = 0, rdata = 0, ack = 0, busy = 0.
  - Data is high-Z; the last-access-was-read flag (lr) is cleared.
  - A reset in the middle of an access aborts it with no ack.
- States: IDLE, TURN, READ, WSETUP, WPULSE, WHOLD, DONE. All outputs are registered; there are no combinational paths from req to the pins.
- IDLE:
  - CE=1, OE=1, WE=1, Data high-Z.
  - If req=1 on an edge: latch we/addr/wdata/be, then go:
    - READ if we=0;
    - TURN if we=1, lr=1 and TURN_CYC>0;
    - WSETUP otherwise.
  - A req held while busy is ignored; it is accepted only once IDLE is re-entered.
- TURN: lasts TURN_CYC cycles. All strobes high, Data high-Z, ADDR = latched address. Then go to WSETUP.
- READ:
  - CE=0, OE=0, WE=1, BE_N = ~be, Data high-Z; lasts RD_WAIT+1 cycles.
  - On the final edge, capture Data into rdata (all lanes, including disabled ones), set lr=1, go to DONE.
- WSETUP: 1 cycle. CE=0, WE=1, OE=1, BE_N = ~be, Data driven with wdata.
- WPULSE: WR_WAIT+1 cycles. WE=0; everything else as in WSETUP.
- WHOLD: 1 cycle. WE=1, Data still driven. Then set lr=0 and go to DONE.
- DONE: 1 cycle. ack=1, all strobes high, Data high-Z. Go to IDLE.
- Latency, measured from the acceptance edge k:
  - Read: ack high in the cycle after edge k+RD_WAIT+1.
  - Write: ack high in the cycle after edge k+WR_WAIT+3 (plus TURN_CYC when turnaround applies).
  - Minimum spacing between accepted requests is one IDLE cycle after DONE.
- be = 0: the full access sequence still runs with all BE_N high, and ack is still given (no-op access).
- Wait-state counter: width is $clog2 of the largest of RD_WAIT+1, WR_WAIT+1 and TURN_CYC (minimum 1 bit). It is reloaded on every state entry and never wraps.
- ADDR holds the latched address from acceptance until the next acceptance.

Decomposition:
- Shared package sram_pkg:
  - state enum sram_state_t;
  - localparam NBYTE = DATA_W/8 helper;
  - an elaboration-time check that DATA_W % 8 == 0.
- One sub-module, sram_tristate:
  - bidirectional bus buffer with ports oe_drv, dout, din, pad;
  - the only place where Data is driven or set to high-Z.

Test Plan:
- Default parameters, Reset low during an access, then release: all strobes 1, BE_N=2'b11, Data high-Z, ack=0; no ack follows.
- Write addr=20'h00010, wdata=16'hBEEF, be=2'b11: WE low exactly 2 cycles, Data=16'hBEEF from WSETUP through WHOLD, ack 5 cycles after acceptance; test_memory word 0x10 = 0xBEEF.
- Read of addr 0x10 after that write: OE low exactly 2 cycles, ack 3 cycles after acceptance, rdata=16'hBEEF and held after ack.
- Read immediately followed by a write of 16'h1234 to 0x11 (TURN_CYC=1): exactly 1 TURN cycle with Data high-Z, then WSETUP; no cycle where both the SRAM and the controller drive Data.
- Byte write be=2'b01, wdata=16'hAA55 to 0x10 (holding 0xBEEF): BE_N=2'b10 in all active cycles; a read back returns 16'hBE55. Then be=2'b00: ack still given, memory unchanged.
- Parameter sweep DATA_W=32, RD_WAIT=3, WR_WAIT=0: OE low 4 cycles, WE low 1 cycle, BE_N is 4 bits wide, the 32'hDEADBEEF round-trip matches, and req held high during busy is accepted only after DONE.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the asynchronous-SRAM controller.
package sram_pkg;

    // Controller states; one access walks IDLE -> [TURN] -> READ | WSETUP/WPULSE/WHOLD -> DONE.
    typedef enum logic [2:0] {
        StIdle,
        StTurn,
        StRead,
        StWSetup,
        StWPulse,
        StWHold,
        StDone
    } sram_state_t;

    // Byte-lane count for the default 16-bit hookup.
    localparam int unsigned NBYTE = 16 / 8;

    // Byte-lane count for an arbitrary data width.
    function automatic int unsigned nbyte(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // A data bus is legal only when it splits into whole byte lanes.
    function automatic bit data_w_ok(input int unsigned data_w);
        return (data_w != 0) && ((data_w % 8) == 0);
    endfunction

    // Wait-state counter width: enough for the longest multi-cycle state, never below 1 bit.
    function automatic int unsigned cnt_w(input int unsigned rd_wait,
                                          input int unsigned wr_wait,
                                          input int unsigned turn_cyc);
        int unsigned m;
        m = rd_wait + 1;
        if (wr_wait + 1 > m) m = wr_wait + 1;
        if (turn_cyc > m) m = turn_cyc;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sram_tristate.sv
// Bidirectional buffer for the SRAM data bus; the only driver of the pad.
module sram_tristate #(
    parameter int unsigned Width = 16
) (
    input  logic             oe_drv,
    input  logic [Width-1:0] dout,
    output logic [Width-1:0] din,
    inout  wire  [Width-1:0] pad
);

    assign pad = oe_drv ? dout : {Width{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM controller: single-cycle request handshake in, timed SRAM strobes out.
// Every pin and status output is a flop loaded from the next state, so nothing on the
// request side reaches the SRAM combinationally.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned RD_WAIT  = 1,
    parameter int unsigned WR_WAIT  = 1,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                busy,
    output logic                ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                CE,
    output logic                OE,
    output logic                WE,
    output logic [DATA_W/8-1:0] BE_N,
    output logic [ADDR_W-1:0]   ADDR,
    inout  wire  [DATA_W-1:0]   Data
);

    localparam int unsigned NB = nbyte(DATA_W);
    localparam int unsigned CW = cnt_w(RD_WAIT, WR_WAIT, TURN_CYC);

    // Counter reload values are "length - 1"; a state exits when the counter reads zero.
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_WAIT);
    localparam logic [CW-1:0] WR_LAST   = CW'(WR_WAIT);
    localparam logic [CW-1:0] TURN_LAST = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("sram_ctrl: DATA_W must be a non-zero multiple of 8");
    end

    sram_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic              lr_q, lr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ce_q, ce_d;
    logic              oe_q, oe_d;
    logic              we_n_q, we_n_d;
    logic [NB-1:0]     ben_q, ben_d;
    logic              drv_q, drv_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] din;
    logic              active;

    // Next-state, wait-state counter and latched request fields.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        lr_d    = lr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    if (!we) begin
                        state_d = StRead;
                        cnt_d   = RD_LAST;
                    end else if (lr_q && (TURN_CYC > 0)) begin
                        // SRAM may still be releasing the bus after the previous read.
                        state_d = StTurn;
                        cnt_d   = TURN_LAST;
                    end else begin
                        state_d = StWSetup;
                        cnt_d   = '0;
                    end
                end
            end
            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StWSetup;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StRead: begin
                if (cnt_q == '0) begin
                    rdata_d = din;
                    lr_d    = 1'b1;
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StWSetup: begin
                state_d = StWPulse;
                cnt_d   = WR_LAST;
            end
            StWPulse: begin
                if (cnt_q == '0) begin
                    state_d = StWHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StWHold: begin
                lr_d    = 1'b0;
                state_d = StDone;
                cnt_d   = '0;
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values for the state being entered, so the output flops line up with state_q.
    always_comb begin
        active = (state_d == StRead) || (state_d == StWSetup) ||
                 (state_d == StWPulse) || (state_d == StWHold);
        ce_d   = ~active;
        oe_d   = (state_d != StRead);
        we_n_d = (state_d != StWPulse);
        ben_d  = active ? ~be_d : '1;
        drv_d  = (state_d == StWSetup) || (state_d == StWPulse) || (state_d == StWHold);
        ack_d  = (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    // State, latched request and registered pins; reset aborts any access without an ack.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            lr_q    <= 1'b0;
            rdata_q <= '0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_n_q  <= 1'b1;
            ben_q   <= '1;
            drv_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            lr_q    <= lr_d;
            rdata_q <= rdata_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
            ben_q   <= ben_d;
            drv_q   <= drv_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign CE    = ce_q;
    assign OE    = oe_q;
    assign WE    = we_n_q;
    assign BE_N  = ben_q;
    assign ADDR  = addr_q;

    sram_tristate #(
        .Width (DATA_W)
    ) u_tristate (
        .oe_drv (drv_q),
        .dout   (wdata_q),
        .din    (din),
        .pad    (Data)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default 16-bit instance plus a 32-bit/RD_WAIT=3/WR_WAIT=0 one.
// The memory model drives a fixed keeper pattern whenever CE is high, so a controller that
// fails to release the bus corrupts the pattern and shows up on the data checks.
module tb_sram_ctrl;

    localparam logic [15:0] PAT16 = 16'hC3C3;
    localparam logic [31:0] PAT32 = 32'hC3C3C3C3;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic        req16, we16, busy16, ack16, CE16, OE16, WE16;
    logic [19:0] addr16, ADDR16;
    logic [15:0] wdata16, rdata16;
    logic [1:0]  be16, BE_N16;
    wire  [15:0] data16;

    logic        req32, we32, busy32, ack32, CE32, OE32, WE32;
    logic [19:0] addr32, ADDR32;
    logic [31:0] wdata32, rdata32;
    logic [3:0]  be32, BE_N32;
    wire  [31:0] data32;

    sram_ctrl dut16 (
        .Clk(Clk), .Reset(Reset), .req(req16), .we(we16), .addr(addr16), .wdata(wdata16),
        .be(be16), .busy(busy16), .ack(ack16), .rdata(rdata16), .CE(CE16), .OE(OE16),
        .WE(WE16), .BE_N(BE_N16), .ADDR(ADDR16), .Data(data16)
    );

    sram_ctrl #(
        .DATA_W(32), .ADDR_W(20), .RD_WAIT(3), .WR_WAIT(0), .TURN_CYC(1)
    ) dut32 (
        .Clk(Clk), .Reset(Reset), .req(req32), .we(we32), .addr(addr32), .wdata(wdata32),
        .be(be32), .busy(busy32), .ack(ack32), .rdata(rdata32), .CE(CE32), .OE(OE32),
        .WE(WE32), .BE_N(BE_N32), .ADDR(ADDR32), .Data(data32)
    );

    logic [15:0] mem16 [0:255];
    logic [31:0] mem32 [0:255];

    assign data16 = (!CE16 && !OE16) ? mem16[ADDR16[7:0]] : (CE16 ? PAT16 : 16'hzzzz);
    assign data32 = (!CE32 && !OE32) ? mem32[ADDR32[7:0]] : (CE32 ? PAT32 : 32'hzzzzzzzz);

    always @(posedge WE16) begin
        if (!CE16) for (int i = 0; i < 2; i++)
            if (!BE_N16[i]) mem16[ADDR16[7:0]][i*8 +: 8] <= data16[i*8 +: 8];
    end

    always @(posedge WE32) begin
        if (!CE32) for (int i = 0; i < 4; i++)
            if (!BE_N32[i]) mem32[ADDR32[7:0]][i*8 +: 8] <= data32[i*8 +: 8];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One access on the 16-bit instance, observed cycle by cycle from the acceptance edge.
    task automatic access16(input logic w, input logic [19:0] a, input logic [15:0] d,
                            input logic [1:0] b, output int lat, output int oe_lo,
                            output int we_lo, output int turn, output int ben_bad,
                            output int data_bad);
        int cyc;
        lat = 0; oe_lo = 0; we_lo = 0; turn = 0; ben_bad = 0; data_bad = 0; cyc = 0;
        @(negedge Clk);
        req16 = 1'b1; we16 = w; addr16 = a; wdata16 = d; be16 = b;
        @(posedge Clk);
        #1 req16 = 1'b0;
        while (cyc < 20 && lat == 0) begin
            @(negedge Clk);
            cyc++;
            if (!OE16) oe_lo++;
            if (!WE16) we_lo++;
            if (busy16 && CE16 && !ack16) begin
                turn++;
                if (data16 !== PAT16) data_bad++;
            end
            if (!CE16 && (BE_N16 !== ~b)) ben_bad++;
            if (!CE16 && OE16 && (data16 !== d)) data_bad++;
            if (ack16) lat = cyc;
        end
    endtask

    task automatic access32(input logic w, input logic [19:0] a, input logic [31:0] d,
                            input logic [3:0] b, output int lat, output int oe_lo,
                            output int we_lo, output int ben_bad, output int data_bad);
        int cyc;
        lat = 0; oe_lo = 0; we_lo = 0; ben_bad = 0; data_bad = 0; cyc = 0;
        @(negedge Clk);
        req32 = 1'b1; we32 = w; addr32 = a; wdata32 = d; be32 = b;
        @(posedge Clk);
        #1 req32 = 1'b0;
        while (cyc < 20 && lat == 0) begin
            @(negedge Clk);
            cyc++;
            if (!OE32) oe_lo++;
            if (!WE32) we_lo++;
            if (!CE32 && (BE_N32 !== ~b)) ben_bad++;
            if (!CE32 && OE32 && (data32 !== d)) data_bad++;
            if (ack32) lat = cyc;
        end
    endtask

    typedef struct {
        logic        w;
        logic [19:0] a;
        logic [15:0] d;
        logic [1:0]  b;
        int          lat;
        int          oe_lo;
        int          we_lo;
        int          turn;
        logic        chk_rd;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vec_t v;
        int lat, oe_lo, we_lo, turn, ben_bad, data_bad, acks, a1, a2, busy_gap;

        //            w     addr        wdata     be     lat oe we turn chk   rdata
        vecs[0] = '{1'b1, 20'h00010, 16'hBEEF, 2'b11, 5, 0, 2, 0, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 3, 2, 0, 0, 1'b1, 16'hBEEF};
        vecs[2] = '{1'b1, 20'h00011, 16'h1234, 2'b11, 6, 0, 2, 1, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 20'h00010, 16'hAA55, 2'b01, 5, 0, 2, 0, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 3, 2, 0, 0, 1'b1, 16'hBE55};
        vecs[5] = '{1'b1, 20'h00010, 16'hFFFF, 2'b00, 6, 0, 2, 1, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 3, 2, 0, 0, 1'b1, 16'hBE55};
        vecs[7] = '{1'b0, 20'h00011, 16'h0000, 2'b11, 3, 2, 0, 0, 1'b1, 16'h1234};

        for (int i = 0; i < 256; i++) begin
            mem16[i] = '0;
            mem32[i] = '0;
        end
        Reset = 1'b0;
        req16 = 0; we16 = 0; addr16 = '0; wdata16 = '0; be16 = '0;
        req32 = 0; we32 = 0; addr32 = '0; wdata32 = '0; be32 = '0;

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_strobes16", 32'({CE16, OE16, WE16, BE_N16}), 32'h1F);
        check("rst_status16", 32'({ack16, busy16, ADDR16}), 32'h0);
        check("rst_rdata16", 32'(rdata16), 32'h0);
        check("rst_bus16", 32'(data16), 32'(PAT16));
        check("rst_strobes32", 32'({CE32, OE32, WE32, BE_N32}), 32'h7F);
        Reset = 1'b1;

        // Write aborted by reset while WE is low.
        @(negedge Clk);
        req16 = 1'b1; we16 = 1'b1; addr16 = 20'h00020; wdata16 = 16'h5555; be16 = 2'b11;
        @(posedge Clk);
        #1 req16 = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_in_pulse", 32'(WE16), 32'h0);
        #2 Reset = 1'b0;
        #1;
        check("abort_strobes", 32'({CE16, OE16, WE16, BE_N16}), 32'h1F);
        check("abort_status", 32'({ack16, busy16, ADDR16}), 32'h0);
        check("abort_bus", 32'(data16), 32'(PAT16));
        @(negedge Clk);
        Reset = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge Clk);
            if (ack16) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'h0);

        foreach (vecs[i]) begin
            v = vecs[i];
            access16(v.w, v.a, v.d, v.b, lat, oe_lo, we_lo, turn, ben_bad, data_bad);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
            check($sformatf("v%0d_oe_low", i), 32'(oe_lo), 32'(v.oe_lo));
            check($sformatf("v%0d_we_low", i), 32'(we_lo), 32'(v.we_lo));
            check($sformatf("v%0d_turn", i), 32'(turn), 32'(v.turn));
            check($sformatf("v%0d_be_n", i), 32'(ben_bad), 32'h0);
            check($sformatf("v%0d_bus", i), 32'(data_bad), 32'h0);
            if (v.chk_rd) begin
                check($sformatf("v%0d_rdata", i), 32'(rdata16), 32'(v.rd));
                @(negedge Clk);
                check($sformatf("v%0d_rdata_hold", i), 32'(rdata16), 32'(v.rd));
            end
            if (i == 0) check("mem_0x10", 32'(mem16[16]), 32'h0000BEEF);
        end

        // 32-bit instance round trip.
        access32(1'b1, 20'h00005, 32'hDEADBEEF, 4'hF, lat, oe_lo, we_lo, ben_bad, data_bad);
        check("w32_latency", 32'(lat), 32'd4);
        check("w32_we_low", 32'(we_lo), 32'd1);
        check("w32_oe_low", 32'(oe_lo), 32'd0);
        check("w32_be_n", 32'(ben_bad), 32'h0);
        check("w32_bus", 32'(data_bad), 32'h0);
        access32(1'b0, 20'h00005, 32'h0, 4'hF, lat, oe_lo, we_lo, ben_bad, data_bad);
        check("r32_latency", 32'(lat), 32'd5);
        check("r32_oe_low", 32'(oe_lo), 32'd4);
        check("r32_we_low", 32'(we_lo), 32'd0);
        check("r32_rdata", rdata32, 32'hDEADBEEF);

        // req held high across a whole access: second acceptance only after DONE + IDLE.
        @(negedge Clk);
        req32 = 1'b1; we32 = 1'b0; addr32 = 20'h00005; be32 = 4'hF;
        @(posedge Clk);
        acks = 0; a1 = 0; a2 = 0; busy_gap = 1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge Clk);
            if (a1 != 0 && c == a1 + 1) busy_gap = int'(busy32);
            if (ack32) begin
                acks++;
                if (a1 == 0) a1 = c;
                else if (a2 == 0) begin
                    a2 = c;
                    req32 = 1'b0;
                end
            end
        end
        req32 = 1'b0;
        check("held_first_ack", 32'(a1), 32'd5);
        check("held_idle_gap", 32'(busy_gap), 32'd0);
        check("held_second_ack", 32'(a2), 32'd11);
        check("held_ack_count", 32'(acks), 32'd2);
        check("held_idle_be_n", 32'(BE_N32), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
